// File: rtl/ws281x_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws281x_pkg
// Brief    : Shared WS281x types, timing defaults and ns-to-cycles helper.
// Revision : 1.0 - initial release
// ============================================================================
package ws281x_pkg;

   // Receiver decode state
   typedef enum logic [1:0] {
      SYNC = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } ws281x_state_e;

   // Nominal line timing shared by the driver and the receiver
   localparam int unsigned c_t0h_ns   = 400;
   localparam int unsigned c_t1h_ns   = 800;
   localparam int unsigned c_reset_ns = 50_000;

   // Convert a duration in ns to whole clock cycles (truncated); the
   // intermediate is 64 bits so long gaps at high clock rates cannot wrap.
   function automatic int unsigned ns_to_cycles(input int unsigned clk_freq,
                                                input int unsigned ns);
      logic [63:0] v;
      v = ((64'(clk_freq) / 64'd1000) * 64'(ns)) / 64'd1_000_000;
      return v[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/prim_flop_2sync.sv
`default_nettype none
// ============================================================================
// Module   : prim_flop_2sync
// Brief    : Two-flop synchroniser for signals crossing into clk_i.
// Revision : 1.0 - initial release
// ============================================================================
module prim_flop_2sync #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two back-to-back flops let a metastable first stage settle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/ws281x_rx.sv
`default_nettype none
// ============================================================================
// Module   : ws281x_rx
// Brief    : WS281x NRZ serial receiver; recovers 24-bit words MSB-first,
//            flags the latch gap, decode errors and dropped words.
// Revision : 1.0 - initial release
// ============================================================================
module ws281x_rx
   import ws281x_pkg::*;
#(
   parameter int unsigned ClkFreq        = 25_000_000,
   parameter int unsigned MinHighNs      = 150,
   parameter int unsigned BitThresholdNs = 600,
   parameter int unsigned MaxHighNs      = 5000,
   parameter int unsigned ResetNs        = c_reset_ns
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ws281x_din_i,
   output logic [23:0] data_o,
   output logic        data_valid_o,
   input  logic        data_ack_i,
   output logic        frame_end_o,
   output logic        error_o,
   output logic        overflow_o
);

   localparam int unsigned c_min_cycles   = ns_to_cycles(ClkFreq, MinHighNs);
   localparam int unsigned c_th_cycles    = ns_to_cycles(ClkFreq, BitThresholdNs);
   localparam int unsigned c_max_cycles   = ns_to_cycles(ClkFreq, MaxHighNs);
   localparam int unsigned c_reset_cycles = ns_to_cycles(ClkFreq, ResetNs);
   localparam int unsigned c_cnt_w        = $clog2(c_reset_cycles + 1);

   localparam logic [c_cnt_w-1:0] c_min_q   = c_cnt_w'(c_min_cycles);
   localparam logic [c_cnt_w-1:0] c_th_q    = c_cnt_w'(c_th_cycles);
   localparam logic [c_cnt_w-1:0] c_max_q   = c_cnt_w'(c_max_cycles);
   localparam logic [c_cnt_w-1:0] c_reset_q = c_cnt_w'(c_reset_cycles);
   localparam logic [c_cnt_w-1:0] c_gap_q   = c_cnt_w'(c_reset_cycles - 1);

   logic               w_din_sync;
   logic               r_din_q;
   logic               w_rise;
   logic               w_fall;
   logic [c_cnt_w-1:0] r_cnt;

   ws281x_state_e      r_state;
   ws281x_state_e      w_state_nxt;
   logic               w_shift;
   logic               w_bit_val;
   logic               w_gap;
   logic               w_frame_end;
   logic               w_err;

   logic [22:0]        r_shift;
   logic [4:0]         r_bit_cnt;
   logic               r_word_seen;
   logic [23:0]        r_data;
   logic               r_valid;
   logic               r_frame_end;
   logic               r_error;
   logic               r_overflow;

   prim_flop_2sync #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (ws281x_din_i),
      .q_o    (w_din_sync)
   );

   // Delayed copy of the synchronised line for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_din_q <= 1'b0;
      else         r_din_q <= w_din_sync;
   end

   assign w_rise = w_din_sync & ~r_din_q;
   assign w_fall = ~w_din_sync & r_din_q;

   // Level-duration counter: restarts on every edge, saturates at the gap length
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 r_cnt <= '0;
      else if (w_rise || w_fall)   r_cnt <= '0;
      else if (r_cnt != c_reset_q) r_cnt <= r_cnt + c_cnt_w'(1);
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= SYNC;
      else         r_state <= w_state_nxt;
   end

   // Next state and decode strobes; the gap strobe fires on the cycle the
   // counter is about to reach the gap length, so it fires once per gap
   always_comb begin
      w_state_nxt = r_state;
      w_shift     = 1'b0;
      w_bit_val   = 1'b0;
      w_gap       = 1'b0;
      w_frame_end = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         SYNC: begin
            if (!w_din_sync && (r_cnt == c_reset_q)) w_state_nxt = LOW;
         end
         LOW: begin
            if (w_rise) begin
               w_state_nxt = HIGH;
            end else if (r_cnt == c_gap_q) begin
               w_gap = 1'b1;
               if (r_bit_cnt != 5'd0) w_err       = 1'b1;
               else if (r_word_seen)  w_frame_end = 1'b1;
            end
         end
         HIGH: begin
            if (w_fall) begin
               if (r_cnt < c_min_q) begin
                  w_err       = 1'b1;
                  w_state_nxt = SYNC;
               end else begin
                  w_shift     = 1'b1;
                  w_bit_val   = (r_cnt >= c_th_q);
                  w_state_nxt = LOW;
               end
            end else if (r_cnt >= c_max_q) begin
               w_err       = 1'b1;
               w_state_nxt = SYNC;
            end
         end
         default: w_state_nxt = SYNC;
      endcase
   end

   // Bit assembly, word hand-off, handshake and event pulses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_word_seen <= 1'b0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_end <= 1'b0;
         r_error     <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_end <= w_frame_end;
         r_error     <= w_err;
         r_overflow  <= 1'b0;
         if (data_ack_i && r_valid) r_valid <= 1'b0;
         if (w_err || w_gap) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_seen <= 1'b0;
         end else if (w_shift) begin
            if (r_bit_cnt == 5'd23) begin
               r_shift     <= '0;
               r_bit_cnt   <= '0;
               r_word_seen <= 1'b1;
               // An ack in the same cycle frees the holding register
               if (!r_valid || data_ack_i) begin
                  r_data  <= {r_shift, w_bit_val};
                  r_valid <= 1'b1;
               end else begin
                  r_overflow <= 1'b1;
               end
            end else begin
               r_shift   <= {r_shift[21:0], w_bit_val};
               r_bit_cnt <= r_bit_cnt + 5'd1;
            end
         end
      end
   end

   assign data_o       = r_data;
   assign data_valid_o = r_valid;
   assign frame_end_o  = r_frame_end;
   assign error_o      = r_error;
   assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ws281x_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws281x_rx
// Brief    : Self-checking bench for ws281x_rx with an expected-word queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws281x_rx;

   logic        clk_sys;
   logic        rst_sys_n;
   logic        din;
   logic [23:0] data;
   logic        data_valid;
   logic        data_ack;
   logic        frame_end;
   logic        error;
   logic        overflow;

   int          n_checks;
   int          n_fail;
   int          n_frame_end;
   int          n_error;
   int          n_overflow;
   logic        r_prev_valid;
   logic [23:0] exp_q[$];

   ws281x_rx u_dut (
      .clk_i        (clk_sys),
      .rst_ni       (rst_sys_n),
      .ws281x_din_i (din),
      .data_o       (data),
      .data_valid_o (data_valid),
      .data_ack_i   (data_ack),
      .frame_end_o  (frame_end),
      .error_o      (error),
      .overflow_o   (overflow)
   );

   // 25 MHz clock
   initial clk_sys = 1'b0;
   always #20 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Word monitor and event counters, sampled mid-cycle
   initial r_prev_valid = 1'b0;
   always @(negedge clk_sys) begin
      if (frame_end) n_frame_end++;
      if (error)     n_error++;
      if (overflow)  n_overflow++;
      if (data_valid && !r_prev_valid) begin
         if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
         else                   check("word", data, exp_q.pop_front());
      end
      r_prev_valid = data_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_bit(input logic b);
      din = 1'b1;
      tick(b ? 20 : 10);
      din = 1'b0;
      tick(b ? 11 : 21);
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic gap();
      din = 1'b0;
      tick(1300);
   endtask

   task automatic ack_pulse();
      data_ack = 1'b1;
      tick(1);
      data_ack = 1'b0;
      tick(2);
   endtask

   initial begin
      int fe0, er0, ov0;
      n_checks = 0; n_fail = 0;
      n_frame_end = 0; n_error = 0; n_overflow = 0;
      rst_sys_n = 1'b0; din = 1'b0; data_ack = 1'b0;
      tick(5);
      check("rst_data", data, 0);
      check("rst_valid", data_valid, 0);
      check("rst_frame_end", frame_end, 0);
      check("rst_error", error, 0);
      check("rst_overflow", overflow, 0);
      rst_sys_n = 1'b1;

      // Single word, then ack
      gap();
      fe0 = n_frame_end; er0 = n_error;
      exp_q.push_back(24'hA53CF0);
      send_word(24'hA53CF0);
      gap();
      check("t1_valid", data_valid, 1);
      check("t1_data", data, 24'hA53CF0);
      check("t1_frame_end", n_frame_end - fe0, 1);
      check("t1_error", n_error - er0, 0);
      ack_pulse();
      check("t1_valid_clr", data_valid, 0);

      // Three streamed words with ack held high
      fe0 = n_frame_end; er0 = n_error;
      data_ack = 1'b1;
      exp_q.push_back(24'h000001); send_word(24'h000001);
      exp_q.push_back(24'hFFFFFF); send_word(24'hFFFFFF);
      exp_q.push_back(24'h5A5A5A); send_word(24'h5A5A5A);
      gap();
      data_ack = 1'b0;
      check("t2_pending", exp_q.size(), 0);
      check("t2_frame_end", n_frame_end - fe0, 1);
      check("t2_error", n_error - er0, 0);
      check("t2_valid", data_valid, 0);

      // Two words without ack: second is dropped
      ov0 = n_overflow;
      exp_q.push_back(24'h0F0F0F);
      send_word(24'h0F0F0F);
      send_word(24'hC3C3C3);
      gap();
      check("t3_overflow", n_overflow - ov0, 1);
      check("t3_data", data, 24'h0F0F0F);
      check("t3_valid", data_valid, 1);
      ack_pulse();
      check("t3_valid_clr", data_valid, 0);

      // Partial word then gap
      fe0 = n_frame_end; er0 = n_error;
      for (int i = 0; i < 12; i++) send_bit(i[0]);
      gap();
      check("t4_error", n_error - er0, 1);
      check("t4_frame_end", n_frame_end - fe0, 0);
      check("t4_valid", data_valid, 0);

      // Too-short high, then a word that must be ignored until a gap
      fe0 = n_frame_end; er0 = n_error;
      din = 1'b1; tick(2); din = 1'b0; tick(21);
      send_word(24'h123456);
      gap();
      check("t5_short_error", n_error - er0, 1);
      check("t5_short_fe", n_frame_end - fe0, 0);
      check("t5_short_valid", data_valid, 0);

      // Too-long high, same recovery rule
      er0 = n_error;
      din = 1'b1; tick(200); din = 1'b0; tick(21);
      send_word(24'h654321);
      gap();
      check("t5_long_error", n_error - er0, 1);
      check("t5_long_valid", data_valid, 0);
      exp_q.push_back(24'h00FF00);
      send_word(24'h00FF00);
      gap();
      check("t5_resume_data", data, 24'h00FF00);
      ack_pulse();

      // Reset mid-word
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      rst_sys_n = 1'b0;
      tick(3);
      check("t6_rst_data", data, 0);
      check("t6_rst_valid", data_valid, 0);
      rst_sys_n = 1'b1;
      er0 = n_error;
      send_word(24'hDEAD01);
      gap();
      check("t6_ignored_valid", data_valid, 0);
      check("t6_error", n_error - er0, 0);
      exp_q.push_back(24'hBEEF02);
      send_word(24'hBEEF02);
      gap();
      check("t6_data", data, 24'hBEEF02);
      check("final_pending", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
